// File: rtl/merger_pkg.sv
// rtl/merger_pkg.sv - shared types and helpers for the 2-way streaming merger
//
// Purpose: merge FSM state encoding, terminator detection and key compare.
// Helpers take maximum-width operands; callers zero-extend their tuples/keys,
// which preserves both the all-zero test and the unsigned ordering.
package merger_pkg;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } state_t;

  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_KEY_WIDTH  = 1024;

  // A terminator is the all-zero tuple; keys are never consulted for it.
  function automatic logic is_term(input logic [MAX_DATA_WIDTH-1:0] tuple);
    return (tuple == '0);
  endfunction

  // True when A goes first; equal keys favour A so the merge stays stable.
  function automatic logic a_wins(input logic [MAX_KEY_WIDTH-1:0] a,
                                  input logic [MAX_KEY_WIDTH-1:0] b,
                                  input logic                     descending);
    return descending ? (a >= b) : (a <= b);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO
//
// Purpose: single-clock FIFO whose head is visible on o_data without a read.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_push, i_data      enqueue (ignored when full)
//   i_pop               dequeue the head (ignored when empty)
//   o_data              head tuple, zero when empty
//   o_full, o_empty     status
//   o_count             occupancy, 0..DEPTH
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign o_count = count;
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  // Gate the head so an empty FIFO never shows stale storage contents.
  assign o_data = o_empty ? '0 : mem[rptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/merger_2way_param.sv
// rtl/merger_2way_param.sv - parametrised 2-to-1 sorted-run streaming merger
//
// Purpose: merges two sorted, zero-terminated runs into one sorted run closed
// by a single terminator, one tuple per cycle.
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_fifo_1/2, i_fifo_1/2_empty     upstream FWFT heads for A / B
//   o_fifo_1/2_read                  pop upstream A / B
//   i_fifo_out_ready                 downstream can accept
//   o_out_fifo_write, o_data         downstream write strobe and tuple
//   o_run_count                      completed merged runs (wraps)
//   o_idle                           nothing buffered and FSM in MERGE
module merger_2way_param
  import merger_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80,
  parameter int IN_DEPTH   = 16,
  parameter int OUT_DEPTH  = 32,
  parameter int DESCENDING = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_fifo_1,
  input  logic                  i_fifo_1_empty,
  output logic                  o_fifo_1_read,
  input  logic [DATA_WIDTH-1:0] i_fifo_2,
  input  logic                  i_fifo_2_empty,
  output logic                  o_fifo_2_read,
  input  logic                  i_fifo_out_ready,
  output logic                  o_out_fifo_write,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [15:0]           o_run_count,
  output logic                  o_idle
);

  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;
  localparam logic DESC = (DESCENDING != 0);

  logic [DATA_WIDTH-1:0] a_head, b_head, out_head;
  logic                  a_full, a_empty, b_full, b_empty, out_full, out_empty;
  logic [ICW-1:0]        a_count, b_count;
  logic [OCW-1:0]        out_count;

  logic                  pop_a, pop_b, out_pop;
  logic                  sel_valid, sel_term;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  stall;
  logic                  a_term, b_term;
  logic [15:0]           run_count;
  state_t                state, state_n;

  logic [MAX_DATA_WIDTH-1:0] ext_a, ext_b;
  logic [MAX_KEY_WIDTH-1:0]  key_a, key_b;

  // Upstream gating keeps the input FIFOs from overflowing; reset forces the
  // read strobes low so nothing is consumed while buffers are being cleared.
  assign o_fifo_1_read = ~i_rst & ~i_fifo_1_empty & ~a_full;
  assign o_fifo_2_read = ~i_rst & ~i_fifo_2_empty & ~b_full;

  sync_fifo_fwft #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_a_fifo (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_push(o_fifo_1_read), .i_data(i_fifo_1), .i_pop(pop_a),
    .o_data(a_head), .o_full(a_full), .o_empty(a_empty), .o_count(a_count)
  );

  sync_fifo_fwft #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_b_fifo (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_push(o_fifo_2_read), .i_data(i_fifo_2), .i_pop(pop_b),
    .o_data(b_head), .o_full(b_full), .o_empty(b_empty), .o_count(b_count)
  );

  sync_fifo_fwft #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_push(s1_valid), .i_data(s1_data), .i_pop(out_pop),
    .o_data(out_head), .o_full(out_full), .o_empty(out_empty), .o_count(out_count)
  );

  assign out_pop          = i_fifo_out_ready & ~out_empty;
  assign o_out_fifo_write = out_pop;
  assign o_data           = out_head;
  assign o_run_count      = run_count;
  assign o_idle           = (a_count == '0) && (b_count == '0) && (out_count == '0) &&
                            !s1_valid && (state == MERGE);

  always_comb begin
    ext_a = '0;
    ext_b = '0;
    key_a = '0;
    key_b = '0;
    ext_a[DATA_WIDTH-1:0] = a_head;
    ext_b[DATA_WIDTH-1:0] = b_head;
    key_a[KEY_WIDTH-1:0]  = a_head[KEY_WIDTH-1:0];
    key_b[KEY_WIDTH-1:0]  = b_head[KEY_WIDTH-1:0];
  end

  assign a_term = ~a_empty & is_term(ext_a);
  assign b_term = ~b_empty & is_term(ext_b);

  // Credit: the tuple in S1 is already committed to the out FIFO, so it counts
  // against the free space before another selection is allowed.
  assign stall = out_full || ((int'(out_count) + int'(s1_valid)) >= (OUT_DEPTH - 2));

  always_comb begin
    state_n   = state;
    pop_a     = 1'b0;
    pop_b     = 1'b0;
    sel_valid = 1'b0;
    sel_term  = 1'b0;
    sel_data  = '0;
    if (!stall) begin
      case (state)
        MERGE: begin
          if (!a_empty && !b_empty) begin
            if (a_term && b_term) begin
              pop_a     = 1'b1;
              pop_b     = 1'b1;
              sel_valid = 1'b1;
              sel_term  = 1'b1;
            end else if (a_term) begin
              state_n = DRAIN_B;
            end else if (b_term) begin
              state_n = DRAIN_A;
            end else if (a_wins(key_a, key_b, DESC)) begin
              pop_a     = 1'b1;
              sel_valid = 1'b1;
              sel_data  = a_head;
            end else begin
              pop_b     = 1'b1;
              sel_valid = 1'b1;
              sel_data  = b_head;
            end
          end
        end
        DRAIN_B: begin
          // A's terminator is parked at its head until B's run ends.
          if (!b_empty) begin
            if (!b_term) begin
              pop_b     = 1'b1;
              sel_valid = 1'b1;
              sel_data  = b_head;
            end else if (!a_empty) begin
              pop_a     = 1'b1;
              pop_b     = 1'b1;
              sel_valid = 1'b1;
              sel_term  = 1'b1;
              state_n   = MERGE;
            end
          end
        end
        DRAIN_A: begin
          if (!a_empty) begin
            if (!a_term) begin
              pop_a     = 1'b1;
              sel_valid = 1'b1;
              sel_data  = a_head;
            end else if (!b_empty) begin
              pop_a     = 1'b1;
              pop_b     = 1'b1;
              sel_valid = 1'b1;
              sel_term  = 1'b1;
              state_n   = MERGE;
            end
          end
        end
        default: state_n = MERGE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= MERGE;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      run_count <= '0;
    end else begin
      state    <= state_n;
      s1_valid <= sel_valid;
      s1_data  <= sel_data;
      if (sel_term) begin
        run_count <= run_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_merger_2way_param.sv
// tb/tb_merger_2way_param.sv - scoreboard bench for merger_2way_param
module tb_merger_2way_param;

  localparam int DW = 128;
  localparam int OUT_DEPTH = 32;
  localparam logic [47:0] PA = 48'h0000_0000_000A;
  localparam logic [47:0] PB = 48'h0000_0000_000B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: ascending, instance 1: descending
  logic [DW-1:0] a0_data = '0, b0_data = '0, a1_data = '0, b1_data = '0;
  logic a0_empty = 1'b1, b0_empty = 1'b1, a1_empty = 1'b1, b1_empty = 1'b1;
  logic a0_rd, b0_rd, a1_rd, b1_rd;
  logic rdy0 = 1'b1, rdy1 = 1'b1;
  logic wr0, wr1, idle0, idle1;
  logic [DW-1:0] dout0, dout1;
  logic [15:0] rc0, rc1;

  logic [DW-1:0] qa0[$], qb0[$], qa1[$], qb1[$];
  logic [DW-1:0] exp0[$], exp1[$];
  logic s_a0, s_b0, s_a1, s_b1;

  int checks = 0;
  int errors = 0;
  int out_cnt0 = 0;
  int max_occ0 = 0;

  merger_2way_param #(.DESCENDING(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_fifo_1(a0_data), .i_fifo_1_empty(a0_empty), .o_fifo_1_read(a0_rd),
    .i_fifo_2(b0_data), .i_fifo_2_empty(b0_empty), .o_fifo_2_read(b0_rd),
    .i_fifo_out_ready(rdy0), .o_out_fifo_write(wr0), .o_data(dout0),
    .o_run_count(rc0), .o_idle(idle0)
  );

  merger_2way_param #(.DESCENDING(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_fifo_1(a1_data), .i_fifo_1_empty(a1_empty), .o_fifo_1_read(a1_rd),
    .i_fifo_2(b1_data), .i_fifo_2_empty(b1_empty), .o_fifo_2_read(b1_rd),
    .i_fifo_out_ready(rdy1), .o_out_fifo_write(wr1), .o_data(dout1),
    .o_run_count(rc1), .o_idle(idle1)
  );

  function automatic logic [DW-1:0] mk(input int key, input logic [47:0] pay);
    logic [79:0] k;
    k = 80'(key);
    return {pay, k};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // upstream FWFT models: sample the read strobe mid-cycle, pop after the edge
  initial forever begin
    @(negedge clk);
    s_a0 = a0_rd; s_b0 = b0_rd; s_a1 = a1_rd; s_b1 = b1_rd;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (s_a0 && qa0.size() > 0) void'(qa0.pop_front());
    if (s_b0 && qb0.size() > 0) void'(qb0.pop_front());
    if (s_a1 && qa1.size() > 0) void'(qa1.pop_front());
    if (s_b1 && qb1.size() > 0) void'(qb1.pop_front());
    a0_empty = (qa0.size() == 0); a0_data = a0_empty ? '0 : qa0[0];
    b0_empty = (qb0.size() == 0); b0_data = b0_empty ? '0 : qb0[0];
    a1_empty = (qa1.size() == 0); a1_data = a1_empty ? '0 : qa1[0];
    b1_empty = (qb1.size() == 0); b1_data = b1_empty ? '0 : qb1[0];
  end

  // monitors
  initial forever begin
    logic [DW-1:0] e;
    @(negedge clk);
    if (wr0) begin
      out_cnt0++;
      if (exp0.size() == 0) begin
        checks++; errors++;
        $display("FAIL out0_unexpected: got %h expected none", dout0);
      end else begin
        e = exp0.pop_front();
        chk("out0", dout0, e);
      end
    end
    if (int'(dut0.u_out_fifo.o_count) > max_occ0) max_occ0 = int'(dut0.u_out_fifo.o_count);
  end

  initial forever begin
    logic [DW-1:0] e;
    @(negedge clk);
    if (wr1) begin
      if (exp1.size() == 0) begin
        checks++; errors++;
        $display("FAIL out1_unexpected: got %h expected none", dout1);
      end else begin
        e = exp1.pop_front();
        chk("out1", dout1, e);
      end
    end
  end

  task automatic wait_drain(input int which, input int budget, input string name);
    bit done = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (which == 0) done = (exp0.size() == 0) && (qa0.size() == 0) && (qb0.size() == 0) && idle0;
      else            done = (exp1.size() == 0) && (qa1.size() == 0) && (qb1.size() == 0) && idle1;
      if (done) break;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s: drain timeout, got not-idle expected idle within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int first_rd, first_wr, burst, base;
    bit hit;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rd1", DW'(a0_rd), '0);
    chk("rst_rd2", DW'(b0_rd), '0);
    chk("rst_wr", DW'(wr0), '0);
    chk("rst_data", dout0, '0);
    chk("rst_rc", DW'(rc0), '0);
    chk("rst_idle", DW'(idle0), DW'(1));
    chk("rst_idle1", DW'(idle1), DW'(1));
    chk("rst_data1", dout1, '0);
    @(posedge clk); #2; rst = 1'b0;

    // ascending basic + descending tie order, run concurrently
    @(negedge clk);
    qa0.push_back(mk(1, PA)); qa0.push_back(mk(4, PA)); qa0.push_back(mk(7, PA)); qa0.push_back('0);
    qb0.push_back(mk(2, PB)); qb0.push_back(mk(3, PB)); qb0.push_back(mk(9, PB)); qb0.push_back('0);
    exp0.push_back(mk(1, PA)); exp0.push_back(mk(2, PB)); exp0.push_back(mk(3, PB));
    exp0.push_back(mk(4, PA)); exp0.push_back(mk(7, PA)); exp0.push_back(mk(9, PB)); exp0.push_back('0);
    qa1.push_back(mk(9, PA)); qa1.push_back(mk(5, PA)); qa1.push_back('0);
    qb1.push_back(mk(8, PB)); qb1.push_back(mk(5, PB)); qb1.push_back(mk(1, PB)); qb1.push_back('0);
    exp1.push_back(mk(9, PA)); exp1.push_back(mk(8, PB)); exp1.push_back(mk(5, PA));
    exp1.push_back(mk(5, PB)); exp1.push_back(mk(1, PB)); exp1.push_back('0);
    wait_drain(0, 200, "basic_asc");
    chk("rc_basic", DW'(rc0), DW'(1));
    wait_drain(1, 200, "basic_desc");
    chk("rc_desc", DW'(rc1), DW'(1));

    // empty and one-sided runs
    @(negedge clk);
    qa0.push_back('0); qa0.push_back('0);
    qb0.push_back(mk(3, PB)); qb0.push_back(mk(6, PB)); qb0.push_back('0); qb0.push_back('0);
    exp0.push_back(mk(3, PB)); exp0.push_back(mk(6, PB)); exp0.push_back('0); exp0.push_back('0);
    wait_drain(0, 200, "one_sided");
    chk("rc_one_sided", DW'(rc0), DW'(3));

    // latency and throughput
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      qa0.push_back(mk(2 * i + 1, PA));
      qb0.push_back(mk(2 * i + 2, PB));
    end
    qa0.push_back('0); qb0.push_back('0);
    for (int k = 1; k <= 16; k++) exp0.push_back(mk(k, (k % 2) ? PA : PB));
    exp0.push_back('0);
    first_rd = -1; first_wr = -1; burst = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (first_rd < 0 && a0_rd) first_rd = c;
      if (wr0) begin
        if (first_wr < 0) first_wr = c;
        if (c - first_wr < 15) burst++;
      end
      if (exp0.size() == 0 && idle0) break;
    end
    chk("latency", DW'(first_wr - first_rd), DW'(3));
    chk("throughput", DW'(burst), DW'(15));
    wait_drain(0, 200, "latency_run");
    chk("rc_latency", DW'(rc0), DW'(4));

    // backpressure: long runs, ready low 50 cycles then random
    @(posedge clk); #2; rdy0 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      qa0.push_back(mk(2 * i + 1, PA));
      qb0.push_back(mk(2 * i + 2, PB));
    end
    qa0.push_back('0); qb0.push_back('0);
    for (int k = 1; k <= 80; k++) exp0.push_back(mk(k, (k % 2) ? PA : PB));
    exp0.push_back('0);
    repeat (50) @(posedge clk);
    #2;
    chk("bp_plateau", DW'(dut0.u_out_fifo.o_count), DW'(OUT_DEPTH - 2));
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      rdy0 = 1'($urandom_range(0, 1));
      if (exp0.size() == 0 && idle0) break;
    end
    rdy0 = 1'b1;
    wait_drain(0, 200, "backpressure");
    chk("bp_max_occ_le_depth", DW'(max_occ0 <= OUT_DEPTH), DW'(1));
    chk("rc_bp", DW'(rc0), DW'(5));

    // reset mid-run
    @(negedge clk);
    qa0.push_back(mk(10, PA)); qa0.push_back(mk(30, PA)); qa0.push_back(mk(50, PA));
    qa0.push_back(mk(70, PA)); qa0.push_back(mk(90, PA)); qa0.push_back('0);
    qb0.push_back(mk(20, PB)); qb0.push_back(mk(40, PB)); qb0.push_back(mk(60, PB));
    qb0.push_back(mk(80, PB)); qb0.push_back(mk(100, PB)); qb0.push_back('0);
    exp0.push_back(mk(10, PA)); exp0.push_back(mk(20, PB)); exp0.push_back(mk(30, PA));
    exp0.push_back(mk(40, PB)); exp0.push_back(mk(50, PA)); exp0.push_back(mk(60, PB));
    exp0.push_back(mk(70, PA)); exp0.push_back(mk(80, PB)); exp0.push_back(mk(90, PA));
    exp0.push_back(mk(100, PB)); exp0.push_back('0);
    base = out_cnt0;
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (out_cnt0 >= base + 5) begin hit = 1; break; end
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL midrun_outputs: got %0d outputs expected 5", out_cnt0 - base);
    end
    rst = 1'b1;
    #1;
    chk("midrst_data", dout0, '0);
    chk("midrst_wr", DW'(wr0), '0);
    chk("midrst_idle", DW'(idle0), DW'(1));
    chk("midrst_rc", DW'(rc0), '0);
    chk("midrst_rd", DW'(a0_rd), '0);
    exp0.delete(); qa0.delete(); qb0.delete();
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;

    @(negedge clk);
    qa0.push_back(mk(5, PA)); qa0.push_back('0);
    qb0.push_back(mk(6, PB)); qb0.push_back('0);
    exp0.push_back(mk(5, PA)); exp0.push_back(mk(6, PB)); exp0.push_back('0);
    wait_drain(0, 200, "post_reset");
    chk("rc_post_reset", DW'(rc0), DW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
